// File: rtl/nibble_serial_cmp.sv
// nibble_serial_cmp: full-width unsigned compare, one nibble per cycle, MSB first, via an external 4-bit slice.
// Optional feature: define NSC_EARLY_EXIT_EN to finish on the first unequal nibble.
module nibble_serial_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    input  logic             slice_gt,
    input  logic             slice_lt,
    input  logic             slice_eq,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic s_gt;
    logic s_lt;
    logic last;
    logic accept;
    logic nxt_gt;
    logic nxt_lt;
    logic exit_run;
    logic eq_unused;

    // gt wins over lt; anything else (including all-zero) reads as equal
    assign s_gt      = slice_gt;
    assign s_lt      = !slice_gt && slice_lt;
    assign eq_unused = slice_eq;
    assign last      = (idx == '0);
    assign accept    = start && (state == IDLE || state == DONE);

`ifdef NSC_EARLY_EXIT_EN
    assign nxt_gt   = s_gt;
    assign nxt_lt   = s_lt;
    assign exit_run = last || s_gt || s_lt;
`else
    logic dec_gt;
    logic dec_lt;

    // a decided result is sticky; later nibbles cannot override it
    assign nxt_gt   = dec_gt || (!dec_lt && s_gt);
    assign nxt_lt   = dec_lt || (!dec_gt && s_lt);
    assign exit_run = last;

    // sticky decision flags, cleared on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
        end else if (accept) begin
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
        end else if (state == RUN) begin
            dec_gt <= nxt_gt;
            dec_lt <= nxt_lt;
        end
    end
`endif

    // control FSM: capture, walk nibbles downward, load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_gt <= 1'b0;
            res_lt <= 1'b0;
            res_eq <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (exit_run) begin
                        state  <= DONE;
                        res_gt <= nxt_gt;
                        res_lt <= nxt_lt;
                        res_eq <= !nxt_gt && !nxt_lt;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        state  <= RUN;
                        idx    <= IW'(NIB - 1);
                        a_q    <= op_a;
                        b_q    <= op_b;
                        res_gt <= 1'b0;
                        res_lt <= 1'b0;
                        res_eq <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // current nibble to the slice, zero outside RUN
    always_comb begin
        cmp_a = 4'h0;
        cmp_b = 4'h0;
        if (state == RUN) begin
            cmp_a = a_q[{idx, 2'b00} +: 4];
            cmp_b = b_q[{idx, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_nibble_serial_cmp.sv
// tb_nibble_serial_cmp: directed checks of nibble_serial_cmp (WIDTH=16)
// with a behavioural 4-bit slice closing the loop.
module tb_nibble_serial_cmp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [3:0]  cmp_a;
    logic [3:0]  cmp_b;
    logic        slice_gt;
    logic        slice_lt;
    logic        slice_eq;
    logic        res_gt;
    logic        res_lt;
    logic        res_eq;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign slice_gt = cmp_a > cmp_b;
    assign slice_lt = cmp_a < cmp_b;
    assign slice_eq = cmp_a == cmp_b;

    nibble_serial_cmp #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_a(op_a),
        .op_b(op_b),
        .busy(busy),
        .done(done),
        .cmp_a(cmp_a),
        .cmp_b(cmp_b),
        .slice_gt(slice_gt),
        .slice_lt(slice_lt),
        .slice_eq(slice_eq),
        .res_gt(res_gt),
        .res_lt(res_lt),
        .res_eq(res_eq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'(0));
        chk({tag, " done"}, 32'(done), 32'(0));
        chk({tag, " cmp_a"}, 32'(cmp_a), 32'(0));
        chk({tag, " cmp_b"}, 32'(cmp_b), 32'(0));
    endtask

    task automatic chk_res(input string tag, input logic g, input logic l, input logic e);
        chk({tag, " res_gt"}, 32'(res_gt), 32'(g));
        chk({tag, " res_lt"}, 32'(res_lt), 32'(l));
        chk({tag, " res_eq"}, 32'(res_eq), 32'(e));
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic g, input logic l, input logic e, input int ex_early);
        int n;
        int ex;
        logic [15:0] sa;
        logic [15:0] sb;
`ifdef NSC_EARLY_EXIT_EN
        ex = ex_early;
`else
        ex = 4;
`endif
        @(negedge clk);
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        sa = '0;
        sb = '0;
        while (!done && n < 8) begin
            chk({tag, " busy"}, 32'(busy), 32'(1));
            sa = {sa[11:0], cmp_a};
            sb = {sb[11:0], cmp_b};
            n++;
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(done), 32'(1));
        chk({tag, " runcyc"}, 32'(n), 32'(ex));
        chk({tag, " busy@done"}, 32'(busy), 32'(0));
        chk({tag, " cmp_a@done"}, 32'(cmp_a), 32'(0));
        chk_res(tag, g, l, e);
`ifndef NSC_EARLY_EXIT_EN
        chk({tag, " seq_a"}, 32'(sa), 32'(a));
        chk({tag, " seq_b"}, 32'(sb), 32'(b));
`endif
    endtask

    initial begin
        int n;
        #1;
        chk_idle("rst");
        chk_res("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1_eq", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 4);
        run_op("t2_gt", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1);
        run_op("t3_lt", 16'h1230, 16'h1231, 1'b0, 1'b1, 1'b0, 4);
        run_op("t4_sticky", 16'h0F00, 16'h0E99, 1'b1, 1'b0, 1'b0, 2);

        @(negedge clk);
        chk_idle("hold");
        chk_res("hold", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_res("hold2", 1'b1, 1'b0, 1'b0);

        run_op("max_gt", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        run_op("zero_eq", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4);
        run_op("min_lt", 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1);

        // start held through RUN, then back-to-back from DONE
        @(negedge clk);
        op_a = 16'h0001;
        op_b = 16'h0002;
        start = 1'b1;
        @(negedge clk);
        op_a = 16'hFFFF;
        op_b = 16'h0000;
        chk("t5 busy", 32'(busy), 32'(1));
        chk("t5 cmp_a ign", 32'(cmp_a), 32'(0));
        n = 0;
        while (!done && n < 8) begin
            n++;
            @(negedge clk);
        end
        chk("t5 done", 32'(done), 32'(1));
        chk_res("t5 first", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("t5 b2b busy", 32'(busy), 32'(1));
        chk("t5 b2b cmp_a", 32'(cmp_a), 32'(4'hF));
        chk("t5 b2b cmp_b", 32'(cmp_b), 32'(0));
        chk_res("t5 cleared", 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!done && n < 8) begin
            n++;
            @(negedge clk);
        end
        chk("t5 done2", 32'(done), 32'(1));
        chk_res("t5 second", 1'b1, 1'b0, 1'b0);

        // reset in the 2nd RUN cycle
        @(negedge clk);
        op_a = 16'h1239;
        op_b = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6 busy1", 32'(busy), 32'(1));
        @(negedge clk);
        chk("t6 busy2", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_idle("t6 rst");
        chk_res("t6 rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6 nodone", 32'(done), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("t6 idle");
        run_op("t6_after", 16'h1239, 16'h1234, 1'b1, 1'b0, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
